// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the execute-stage ALU arbiter: ALU control codes,
// branch classification and the response register state encoding.
package alu_share_arb_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_BEQ  = 4'b1000;
  localparam logic [3:0] ALU_BNE  = 4'b1001;
  localparam logic [3:0] ALU_OR   = 4'b1010;
  localparam logic [3:0] ALU_AND  = 4'b1011;
  localparam logic [3:0] ALU_BLT  = 4'b1100;
  localparam logic [3:0] ALU_BGE  = 4'b1101;
  localparam logic [3:0] ALU_BLTU = 4'b1110;
  localparam logic [3:0] ALU_BGEU = 4'b1111;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  function automatic logic is_branch(input logic [3:0] ctrl);
    return (ctrl == ALU_BEQ)  || (ctrl == ALU_BNE)  ||
           (ctrl == ALU_BLT)  || (ctrl == ALU_BGE)  ||
           (ctrl == ALU_BLTU) || (ctrl == ALU_BGEU);
  endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// One-hot request picker. With ALU_ARB_RR_EN defined the search starts at
// ptr_i and wraps; otherwise the lowest valid index wins.
module alu_rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
`ifdef ALU_ARB_RR_EN
  input  logic [IDW-1:0]  ptr_i,
`endif
  input  logic [NREQ-1:0] valid_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
`ifdef ALU_ARB_RR_EN
    // First pass covers indices at or above the pointer, second pass the wrap.
    for (int i = 0; i < NREQ; i++) begin
      if (!any_o && valid_i[i] && (i >= int'(ptr_i))) begin
        grant_o[i] = 1'b1;
        idx_o      = IDW'(i);
        any_o      = 1'b1;
      end
    end
`endif
    for (int i = 0; i < NREQ; i++) begin
      if (!any_o && valid_i[i]) begin
        grant_o[i] = 1'b1;
        idx_o      = IDW'(i);
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Time-shares one external combinational ALU among NREQ requesters and holds
// the result in a one-entry response register. ALU_ARB_RR_EN selects round-robin.
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*4-1:0]     req_ctrl,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [3:0]            alu_ctrl,
  input  logic [WIDTH-1:0]      alu_out,
  input  logic                  alu_zero,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_zero
);

  rsp_state_e       state_q, state_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   gidx;
  logic             gany;
  logic             can_accept;
  logic             accept;

`ifdef ALU_ARB_RR_EN
  logic [IDW-1:0]   ptr_q, ptr_d;
`endif

  alu_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
`ifdef ALU_ARB_RR_EN
    .ptr_i   (ptr_q),
`endif
    .valid_i (req_valid),
    .grant_o (grant),
    .idx_o   (gidx),
    .any_o   (gany)
  );

  assign rsp_valid  = (state_q == RSP_FULL);
  // A draining response frees the register in the same cycle.
  assign can_accept = ~rsp_valid | rsp_ready;
  assign accept     = gany & can_accept & rst_n;
  assign req_ready  = grant & {NREQ{can_accept & rst_n}};

  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = 4'b0000;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        alu_a    = req_a[i*WIDTH +: WIDTH];
        alu_b    = req_b[i*WIDTH +: WIDTH];
        alu_ctrl = req_ctrl[i*4 +: 4];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    result_d = result_q;
    zero_d   = zero_q;
    if (accept) begin
      state_d = RSP_FULL;
      id_d    = gidx;
      // Branches report only the flag; compute ops report only the result.
      if (is_branch(alu_ctrl)) begin
        result_d = '0;
        zero_d   = alu_zero;
      end else begin
        result_d = alu_out;
        zero_d   = 1'b0;
      end
    end else if (rsp_ready) begin
      state_d = RSP_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RSP_EMPTY;
      id_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

`ifdef ALU_ARB_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: a two-requester instance plus a
// three-requester instance for pointer wrap, each driving a small ALU model.
module tb_alu_share_arb;
  import alu_share_arb_pkg::*;

  logic        clk;
  logic        rst_n;

  logic [1:0]  req_valid, req_ready;
  logic [63:0] req_a, req_b;
  logic [7:0]  req_ctrl;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_ctrl;
  logic        alu_zero;
  logic        rsp_valid, rsp_ready, rsp_zero;
  logic [0:0]  rsp_id;
  logic [31:0] rsp_result;

  logic [2:0]  v3, rr3;
  logic [95:0] a3, b3;
  logic [11:0] c3;
  logic [31:0] alu_a3, alu_b3, alu_out3;
  logic [3:0]  alu_ctrl3;
  logic        alu_zero3;
  logic        rsp_valid3, rsp_ready3, rsp_zero3;
  logic [1:0]  rsp_id3;
  logic [31:0] rsp_result3;

  int checks = 0;
  int errors = 0;

  alu_share_arb #(.NREQ(2), .WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_zero(rsp_zero)
  );

  alu_share_arb #(.NREQ(3), .WIDTH(32)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v3), .req_ready(rr3),
    .req_a(a3), .req_b(b3), .req_ctrl(c3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_ctrl(alu_ctrl3),
    .alu_out(alu_out3), .alu_zero(alu_zero3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_id(rsp_id3), .rsp_result(rsp_result3), .rsp_zero(rsp_zero3)
  );

  // Stand-in for the shared ALU; branch ops put ~(a^b) on the result bus so
  // that result clearing is visible.
  function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] c);
    logic [31:0] o;
    logic        z;
    o = 32'd0;
    z = 1'b0;
    case (c)
      ALU_ADD: o = a + b;
      ALU_SUB: o = a - b;
      ALU_XOR: o = a ^ b;
      ALU_OR:  o = a | b;
      ALU_AND: o = a & b;
      ALU_SLL: o = a << b[4:0];
      default: o = 32'd0;
    endcase
    if (is_branch(c)) begin
      o = ~(a ^ b);
      case (c)
        ALU_BEQ:  z = (a == b);
        ALU_BNE:  z = (a != b);
        ALU_BLT:  z = ($signed(a) < $signed(b));
        ALU_BGE:  z = ($signed(a) >= $signed(b));
        ALU_BLTU: z = (a < b);
        default:  z = (a >= b);
      endcase
    end else begin
      z = (o == 32'd0);
    end
    return {z, o};
  endfunction

  assign {alu_zero, alu_out}   = alu_model(alu_a, alu_b, alu_ctrl);
  assign {alu_zero3, alu_out3} = alu_model(alu_a3, alu_b3, alu_ctrl3);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] c);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_ctrl[i*4 +: 4] = c;
  endtask

  task automatic set_req3(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] c);
    a3[i*32 +: 32] = a;
    b3[i*32 +: 32] = b;
    c3[i*4 +: 4] = c;
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_a = '0; req_b = '0; req_ctrl = '0; rsp_ready = 1'b0;
    v3 = '0; a3 = '0; b3 = '0; c3 = '0; rsp_ready3 = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_id got %0d exp 0", rsp_id); end
    checks++; if (rsp_result !== 32'd0) begin errors++; $display("FAIL reset_result got %h exp 0", rsp_result); end
    checks++; if (rsp_zero !== 1'b0) begin errors++; $display("FAIL reset_zero got %b exp 0", rsp_zero); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    set_req(0, 32'd5, 32'd3, ALU_ADD);
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    #1;
    checks++; if (alu_a !== 32'd5 || alu_b !== 32'd3) begin errors++; $display("FAIL single_alu_ops got %0d,%0d exp 5,3", alu_a, alu_b); end
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b exp 01", req_ready); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL single_id got %0d exp 0", rsp_id); end
    checks++; if (rsp_result !== 32'd8) begin errors++; $display("FAIL single_result got %0d exp 8", rsp_result); end
    checks++; if (rsp_zero !== 1'b0) begin errors++; $display("FAIL single_zero got %b exp 0", rsp_zero); end
    #1;
    checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctrl !== 4'b0000) begin errors++; $display("FAIL idle_alu got %h,%h,%b exp 0,0,0000", alu_a, alu_b, alu_ctrl); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", rsp_valid); end
  endtask

  task automatic test_branch();
    do_reset();
    set_req(1, 32'd7, 32'd7, ALU_BEQ);
    req_valid = 2'b10;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_id !== 1'b1) begin errors++; $display("FAIL beq_id got %0d exp 1", rsp_id); end
    checks++; if (rsp_result !== 32'd0) begin errors++; $display("FAIL beq_result got %h exp 0", rsp_result); end
    checks++; if (rsp_zero !== 1'b1) begin errors++; $display("FAIL beq_zero got %b exp 1", rsp_zero); end
    set_req(1, 32'd7, 32'd7, ALU_BNE);
    @(posedge clk); #1;
    checks++; if (rsp_zero !== 1'b0 || rsp_result !== 32'd0) begin errors++; $display("FAIL bne got zero=%b res=%h exp 0,0", rsp_zero, rsp_result); end
    set_req(1, 32'd7, 32'd7, ALU_SUB);
    @(posedge clk); #1;
    checks++; if (rsp_zero !== 1'b0 || rsp_result !== 32'd0) begin errors++; $display("FAIL sub_zero_clean got zero=%b res=%h exp 0,0", rsp_zero, rsp_result); end
    set_req(1, 32'hFFFF_FFFF, 32'd1, ALU_BLT);
    @(posedge clk); #1;
    checks++; if (rsp_zero !== 1'b1) begin errors++; $display("FAIL blt got %b exp 1", rsp_zero); end
    set_req(1, 32'hFFFF_FFFF, 32'd1, ALU_BLTU);
    @(posedge clk); #1;
    checks++; if (rsp_zero !== 1'b0) begin errors++; $display("FAIL bltu got %b exp 0", rsp_zero); end
    set_req(1, 32'd6, 32'd9, ALU_XOR);
    @(posedge clk); #1;
    checks++; if (rsp_result !== 32'd15 || rsp_zero !== 1'b0) begin errors++; $display("FAIL xor got res=%0d zero=%b exp 15,0", rsp_result, rsp_zero); end
    req_valid = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    int exp_id[4];
`ifdef ALU_ARB_RR_EN
    exp_id = '{0, 1, 0, 1};
`else
    exp_id = '{0, 0, 0, 0};
`endif
    do_reset();
    set_req(0, 32'd1, 32'd1, ALU_ADD);
    set_req(1, 32'd2, 32'd2, ALU_ADD);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if ($countones(req_ready) != 1) begin errors++; $display("FAIL cont_onehot[%0d] got %b exp one bit", k, req_ready); end
      @(posedge clk); #1;
      checks++; if (rsp_id !== 1'(exp_id[k])) begin errors++; $display("FAIL cont_id[%0d] got %0d exp %0d", k, rsp_id, exp_id[k]); end
      checks++; if (rsp_result !== ((exp_id[k] == 0) ? 32'd2 : 32'd4)) begin errors++; $display("FAIL cont_result[%0d] got %0d exp %0d", k, rsp_result, (exp_id[k] == 0) ? 2 : 4); end
    end
    req_valid = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_req(0, 32'd1, 32'd2, ALU_ADD);
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_first_ready got %b exp 01", req_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd3) begin errors++; $display("FAIL bp_first got v=%b res=%0d exp 1,3", rsp_valid, rsp_result); end
    set_req(0, 32'd10, 32'd20, ALU_ADD);
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_stall_ready got %b exp 00", req_ready); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd3) begin errors++; $display("FAIL bp_hold got v=%b res=%0d exp 1,3", rsp_valid, rsp_result); end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_pass_ready got %b exp 01", req_ready); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd30) begin errors++; $display("FAIL bp_second got v=%b res=%0d exp 1,30", rsp_valid, rsp_result); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", rsp_valid); end
  endtask

  task automatic test_reset_full();
    do_reset();
    set_req(0, 32'hFFFF_FFFE, 32'd1, ALU_ADD);
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rf_full got v=%b res=%h exp 1,ffffffff", rsp_valid, rsp_result); end
    set_req(1, 32'd2, 32'd2, ALU_ADD);
    req_valid = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_result !== 32'd0) begin errors++; $display("FAIL rf_async got v=%b res=%h exp 0,0", rsp_valid, rsp_result); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rf_ready_in_reset got %b exp 00", req_ready); end
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rf_first_grant got %b exp 01", req_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_id !== 1'b0 || rsp_result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rf_first_rsp got id=%0d res=%h exp 0,ffffffff", rsp_id, rsp_result); end
    req_valid = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap3();
    do_reset();
    set_req3(1, 32'd3, 32'd3, ALU_ADD);
    set_req3(2, 32'd4, 32'd4, ALU_ADD);
    v3 = 3'b010;
    rsp_ready3 = 1'b1;
    #1;
    checks++; if (rr3 !== 3'b010) begin errors++; $display("FAIL wrap_ready0 got %b exp 010", rr3); end
    @(posedge clk); #1;
    checks++; if (rsp_id3 !== 2'd1 || rsp_result3 !== 32'd6) begin errors++; $display("FAIL wrap_rsp0 got id=%0d res=%0d exp 1,6", rsp_id3, rsp_result3); end
    v3 = 3'b110;
    #1;
`ifdef ALU_ARB_RR_EN
    checks++; if (rr3 !== 3'b100) begin errors++; $display("FAIL wrap_ready1 got %b exp 100", rr3); end
    @(posedge clk); #1;
    checks++; if (rsp_id3 !== 2'd2 || rsp_result3 !== 32'd8) begin errors++; $display("FAIL wrap_rsp1 got id=%0d res=%0d exp 2,8", rsp_id3, rsp_result3); end
`else
    checks++; if (rr3 !== 3'b010) begin errors++; $display("FAIL wrap_ready1 got %b exp 010", rr3); end
    @(posedge clk); #1;
    checks++; if (rsp_id3 !== 2'd1 || rsp_result3 !== 32'd6) begin errors++; $display("FAIL wrap_rsp1 got id=%0d res=%0d exp 1,6", rsp_id3, rsp_result3); end
`endif
    #1;
    checks++; if (rr3 !== 3'b010) begin errors++; $display("FAIL wrap_ready2 got %b exp 010", rr3); end
    @(posedge clk); #1;
    checks++; if (rsp_id3 !== 2'd1) begin errors++; $display("FAIL wrap_rsp2 got id=%0d exp 1", rsp_id3); end
    v3 = 3'b000;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_branch();
    test_contention();
    test_back_to_back();
    test_reset_full();
    test_wrap3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Arbiter and sequencer that time-shares the single combinational ALU in the execute stage between up to four requesters (e.g. the main execute path, the branch comparator path, a CSR/address-generation helper). Each cycle it grants at most one valid request, drives the shared ALU inputs, and captures the result in a one-entry response register with the requester ID. The response path supports backpressure. The block also cleans the ALU's branch/non-branch outputs so consumers never see stale values.

## Interface
- NREQ, 2: number of requesters, legal 2..4
- WIDTH, 32: operand/result width
- IDW, $clog2(NREQ): requester ID width

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  request present, bit i = requester i
- req_ready  out  NREQ  request accepted this cycle when valid & ready
- req_a  in  NREQ*WIDTH  operand a, requester i at [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand b, same packing
- req_ctrl  in  NREQ*4  4-bit alu_ctrl code, requester i at [i*4 +: 4]
- alu_a, alu_b  out  WIDTH  operands to the shared ALU
- alu_ctrl  out  4  control code to the shared ALU
- alu_out  in  WIDTH  ALU result
- alu_zero  in  1  ALU branch flag
- rsp_valid  out  1  response register full
- rsp_ready  in  1  consumer takes response when valid & ready
- rsp_id  out  IDW  index of requester that issued the response
- rsp_result  out  WIDTH  captured result
- rsp_zero  out  1  captured branch-taken flag

## Operation
- Response register FSM: EMPTY (rsp_valid=0), FULL (rsp_valid=1).
- can_accept = ~rsp_valid | rsp_ready (pass-through: a drain and a new accept in the same cycle is allowed).
- Grant is one-hot over req_valid, chosen combinationally; req_ready[i] = grant[i] & can_accept. At most one req_ready bit high.
- alu_a/alu_b/alu_ctrl = granted requester's fields; with no grant they drive 0/0/4'b0000.
- Op classes: branch = ctrl in {1000,1001,1100,1101,1110,1111}; compute = all other codes.
- On accept: rsp_id <= granted index; compute op: rsp_result <= alu_out, rsp_zero <= 0; branch op: rsp_result <= 0, rsp_zero <= alu_zero.
- Transitions: EMPTY→FULL on accept; FULL→EMPTY on rsp_ready with no accept; FULL→FULL on accept (with rsp_ready) or on stall (~rsp_ready, all outputs held stable).
- Requester with valid high and ready low must hold its fields; block does not latch unaccepted requests.
- Undefined ctrl codes (none unused besides listed) pass through; result follows ALU default (0).

## Timing
- Latency: accept in cycle N, rsp_valid/result visible after edge N+1; one op per cycle sustained when rsp_ready=1.
- Grant pointer (see Configuration) updates only on an accepted transfer; stall does not move it.
- Reset (async, any time, including FULL with pending response): rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, pointer=0; pending response is dropped. req_ready low while rst_n low.
- All requesters valid simultaneously: exactly one granted; others see ready=0.

## Configuration
- ALU_ARB_RR_EN defined: round-robin. Pointer p (IDW bits, reset 0); search starts at p, wraps modulo NREQ; after accepting from i, p <= (i+1) mod NREQ (wrap from NREQ-1 to 0).
- Not defined: fixed priority, lowest index wins; pointer register not built.

## Structure
- Shared package: ALU control code constants (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, BEQ, BNE, BLT, BGE, BLTU, BGEU) and an is_branch function; response FSM state enum.
- One sub-module: alu_rr_pick (pointer + valid vector → one-hot grant and index), compiled fixed-priority without the macro.
- Shared ALU instantiated outside this block, at execute-stage level.

## Test plan
- Single requester 0: a=5, b=3, ctrl=0000, rsp_ready=1 → next cycle rsp_valid=1, rsp_id=0, rsp_result=8, rsp_zero=0.
- Branch op: requester 1, a=b=7, ctrl=1000 → rsp_result=0, rsp_zero=1; then ctrl=1001 same operands → rsp_zero=0.
- Contention, RR_EN on: both valid for 4 cycles, rsp_ready=1 → rsp_id sequence 0,1,0,1; macro off → 0,0,0,0.
- Backpressure: rsp_ready=0 after first response (a=1,b=2,ADD) → rsp_result holds 3, req_ready all 0; release rsp_ready → queued request accepted same cycle as drain.
- Async reset while FULL (result 0xFFFF_FFFF) → rsp_valid=0, rsp_result=0 immediately, pointer back to 0; first post-reset grant goes to requester 0.
- NREQ=3 wrap: requesters 1,2 valid, pointer at 2 → grant 2, then pointer wraps to 0, next grant 1.
